// File: rtl/key_scan.sv
// 4x4 matrix keypad scanner: drives one row low per 1 ms dwell, samples the columns,
// debounces whole-matrix snapshots and reports single-key presses and full releases.
module key_scan #(
    parameter logic [15:0] T1MS      = 16'd49999,
    parameter logic [2:0]  DEB_SCANS = 3'd4
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [3:0]  Col_Sig,
    output logic [3:0]  Row_Sig,
    output logic [15:0] Key_State,
    output logic [3:0]  Key_Code,
    output logic        Key_Valid,
    output logic        Key_Release
);

    logic [3:0]  col_s1;
    logic [3:0]  col_s2;
    logic [15:0] tick_cnt;
    logic [1:0]  row_idx;
    logic [11:0] snap;
    logic [15:0] prev_snap;
    logic [2:0]  stab_cnt;

    logic        tick;
    logic [15:0] full_snap;
    logic [2:0]  new_stab;
    logic        update;
    logic        one_hot;
    logic [3:0]  hot_idx;

    assign tick = (tick_cnt == T1MS);

    // Row 3's columns are not stored; they complete the snapshot directly on the last tick.
    assign full_snap = {~col_s2, snap};
    assign one_hot   = (full_snap != 16'h0000) && ((full_snap & (full_snap - 16'd1)) == 16'h0000);
    assign update    = (new_stab == DEB_SCANS) && (full_snap != Key_State);

    always_comb begin
        Row_Sig = 4'b1110;
        case (row_idx)
            2'd0: Row_Sig = 4'b1110;
            2'd1: Row_Sig = 4'b1101;
            2'd2: Row_Sig = 4'b1011;
            2'd3: Row_Sig = 4'b0111;
            default: Row_Sig = 4'b1110;
        endcase
    end

    always_comb begin
        new_stab = 3'd0;
        if (full_snap != prev_snap) begin
            new_stab = 3'd0;
        end else if (stab_cnt >= DEB_SCANS) begin
            new_stab = DEB_SCANS;
        end else begin
            new_stab = stab_cnt + 3'd1;
        end
    end

    always_comb begin
        hot_idx = 4'h0;
        for (int b = 0; b < 16; b++) begin
            if (full_snap[b]) hot_idx = 4'(b);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            col_s1      <= 4'b1111;
            col_s2      <= 4'b1111;
            tick_cnt    <= 16'd0;
            row_idx     <= 2'd0;
            snap        <= 12'h000;
            prev_snap   <= 16'h0000;
            stab_cnt    <= 3'd0;
            Key_State   <= 16'h0000;
            Key_Code    <= 4'h0;
            Key_Valid   <= 1'b0;
            Key_Release <= 1'b0;
        end else begin
            col_s1      <= Col_Sig;
            col_s2      <= col_s1;
            Key_Valid   <= 1'b0;
            Key_Release <= 1'b0;
            if (tick) begin
                tick_cnt <= 16'd0;
                row_idx  <= row_idx + 2'd1;
                case (row_idx)
                    2'd0: snap[3:0]  <= ~col_s2;
                    2'd1: snap[7:4]  <= ~col_s2;
                    2'd2: snap[11:8] <= ~col_s2;
                    default: ;
                endcase
                if (row_idx == 2'd3) begin
                    prev_snap <= full_snap;
                    stab_cnt  <= new_stab;
                    if (update) begin
                        Key_State <= full_snap;
                        if ((Key_State == 16'h0000) && one_hot) begin
                            Key_Valid <= 1'b1;
                            Key_Code  <= hot_idx;
                        end else if ((Key_State != 16'h0000) && (full_snap == 16'h0000)) begin
                            Key_Release <= 1'b1;
                        end
                    end
                end
            end else begin
                tick_cnt <= tick_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_key_scan.sv
// Directed bench for key_scan: a keypad model closes switches between rows and columns,
// and hand-computed cycle points are checked for rows, key state, codes and pulses.
module tb_key_scan;

    logic        CLK;
    logic        RST;
    logic [3:0]  col0, row0, code0;
    logic [15:0] state0;
    logic        valid0, rel0;
    logic [3:0]  col1, row1, code1;
    logic [15:0] state1;
    logic        valid1, rel1;

    logic [15:0] pressed0;
    logic [15:0] pressed1;

    int n_checks;
    int n_errors;
    int valid_cnt0, rel_cnt0, both_cnt;
    int valid_cnt1;

    logic [3:0] row_tab [4];

    key_scan #(.T1MS(16'd3), .DEB_SCANS(3'd2)) dut (
        .CLK(CLK), .RST(RST), .Col_Sig(col0), .Row_Sig(row0),
        .Key_State(state0), .Key_Code(code0), .Key_Valid(valid0), .Key_Release(rel0)
    );

    key_scan #(.T1MS(16'd3), .DEB_SCANS(3'd1)) dut1 (
        .CLK(CLK), .RST(RST), .Col_Sig(col1), .Row_Sig(row1),
        .Key_State(state1), .Key_Code(code1), .Key_Valid(valid1), .Key_Release(rel1)
    );

    // clock / reset
    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // keypad: a closed key pulls its column low while its row is driven low
    always_comb begin
        col0 = 4'b1111;
        col1 = 4'b1111;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (!row0[r] && pressed0[r*4+c]) col0[c] = 1'b0;
                if (!row1[r] && pressed1[r*4+c]) col1[c] = 1'b0;
            end
        end
    end

    always @(negedge CLK) begin
        if (valid0) valid_cnt0 <= valid_cnt0 + 1;
        if (rel0) rel_cnt0 <= rel_cnt0 + 1;
        if ((valid0 && rel0) || (valid1 && rel1)) both_cnt <= both_cnt + 1;
        if (valid1) valid_cnt1 <= valid_cnt1 + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clocks(input int n);
        repeat (n) @(negedge CLK);
    endtask

    // ends on the negedge where RST drops; the next posedge is the first free-running one
    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        clocks(2);
        RST = 1'b0;
    endtask

    initial begin
        int v0, r0;
        row_tab[0] = 4'b1110;
        row_tab[1] = 4'b1101;
        row_tab[2] = 4'b1011;
        row_tab[3] = 4'b0111;
        n_checks = 0; n_errors = 0;
        valid_cnt0 = 0; rel_cnt0 = 0; both_cnt = 0; valid_cnt1 = 0;
        RST = 1'b0;
        pressed0 = 16'h0000;
        pressed1 = 16'h0000;

        // reset values and idle row scanning
        @(negedge CLK);
        RST = 1'b1;
        clocks(2);
        check_eq("rst_row", row0, 4'b1110);
        check_eq("rst_state", state0, 16'h0000);
        check_eq("rst_code", code0, 4'h0);
        check_eq("rst_valid", valid0, 1'b0);
        check_eq("rst_release", rel0, 1'b0);
        RST = 1'b0;
        for (int k = 0; k < 32; k++) begin
            check_eq("idle_row", row0, row_tab[(k / 4) % 4]);
            clocks(1);
        end
        clocks(16 * 4);
        check_eq("idle_state", state0, 16'h0000);
        check_eq("idle_valid_cnt", valid_cnt0, 0);
        check_eq("idle_rel_cnt", rel_cnt0, 0);

        // key 9 (row 2, col 1): accepted at end of third scan, then released
        do_reset();
        v0 = valid_cnt0; r0 = rel_cnt0;
        pressed0 = 16'h0200;
        clocks(47);
        check_eq("k9_early_state", state0, 16'h0000);
        check_eq("k9_early_valid", valid0, 1'b0);
        clocks(1);
        check_eq("k9_state", state0, 16'h0200);
        check_eq("k9_code", code0, 4'h9);
        check_eq("k9_valid", valid0, 1'b1);
        clocks(1);
        check_eq("k9_valid_drop", valid0, 1'b0);
        pressed0 = 16'h0000;
        clocks(46);
        check_eq("k9_rel_early", state0, 16'h0200);
        check_eq("k9_rel_early_pulse", rel0, 1'b0);
        clocks(1);
        check_eq("k9_rel_state", state0, 16'h0000);
        check_eq("k9_rel_pulse", rel0, 1'b1);
        check_eq("k9_code_hold", code0, 4'h9);
        clocks(1);
        check_eq("k9_rel_drop", rel0, 1'b0);
        check_eq("k9_valid_cnt", valid_cnt0 - v0, 1);
        check_eq("k9_rel_cnt", rel_cnt0 - r0, 1);

        // key 5 held, reset pulsed while stability count is 1 (no reset before this)
        v0 = valid_cnt0;
        pressed0 = 16'h0020;
        clocks(16 + 16 + 5);
        RST = 1'b1;
        clocks(1);
        RST = 1'b0;
        check_eq("mid_rst_row", row0, 4'b1110);
        check_eq("mid_rst_state", state0, 16'h0000);
        check_eq("mid_rst_code", code0, 4'h0);
        check_eq("mid_rst_valid", valid0, 1'b0);
        check_eq("mid_rst_release", rel0, 1'b0);
        clocks(47);
        check_eq("k5_early_state", state0, 16'h0000);
        check_eq("k5_no_early_valid", valid_cnt0 - v0, 0);
        clocks(1);
        check_eq("k5_state", state0, 16'h0020);
        check_eq("k5_code", code0, 4'h5);
        check_eq("k5_valid", valid0, 1'b1);
        pressed0 = 16'h0000;

        // bouncing key: snapshot alternates every scan, never accepted
        do_reset();
        v0 = valid_cnt0;
        for (int k = 0; k < 10; k++) begin
            pressed0 = (k % 2 == 0) ? 16'h0200 : 16'h0000;
            clocks(16);
        end
        check_eq("bounce_state", state0, 16'h0000);
        check_eq("bounce_valid_cnt", valid_cnt0 - v0, 0);
        pressed0 = 16'h0000;

        // keys 0 and 15 together: state only, then multi -> single and release
        do_reset();
        v0 = valid_cnt0; r0 = rel_cnt0;
        pressed0 = 16'h8001;
        clocks(50);
        check_eq("multi_state", state0, 16'h8001);
        check_eq("multi_code", code0, 4'h0);
        check_eq("multi_valid_cnt", valid_cnt0 - v0, 0);
        pressed0 = 16'h0001;
        clocks(16 * 4);
        check_eq("m2s_state", state0, 16'h0001);
        check_eq("m2s_valid_cnt", valid_cnt0 - v0, 0);
        check_eq("m2s_code", code0, 4'h0);
        pressed0 = 16'h0000;
        clocks(16 * 4);
        check_eq("multi_rel_state", state0, 16'h0000);
        check_eq("multi_rel_cnt", rel_cnt0 - r0, 1);

        // one-scan debounce: key 0 accepted at end of second scan
        do_reset();
        pressed1 = 16'h0001;
        clocks(31);
        check_eq("d1_early_state", state1, 16'h0000);
        check_eq("d1_early_valid", valid1, 1'b0);
        clocks(1);
        check_eq("d1_state", state1, 16'h0001);
        check_eq("d1_code", code1, 4'h0);
        check_eq("d1_valid", valid1, 1'b1);
        clocks(1);
        check_eq("d1_valid_drop", valid1, 1'b0);
        check_eq("d1_valid_cnt", valid_cnt1, 1);

        check_eq("no_simultaneous_pulses", both_cnt, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/key_scan.md
KEY_SCAN -- requirements
Module: key_scan

Interface
REQ-001 Parameter T1MS, default 16'd49999, meaning last count value of the row-dwell tick counter (1 ms at 50 MHz).
REQ-002 Parameter DEB_SCANS, default 3'd4, meaning consecutive identical full-matrix snapshots required to accept a new key state (range 1..7).
REQ-003 CLK  input  1  system clock; all logic on rising edge.
REQ-004 RST  input  1  synchronous, active-high reset.
REQ-005 Col_Sig  input  4  keypad columns, asynchronous, externally pulled up; low = key closed on the driven row.
REQ-006 Row_Sig  output  4  keypad row drive, active-low one-hot.
REQ-007 Key_State  output  16  debounced key bitmap; bit r*4+c = key at row r, column c, 1 = pressed.
REQ-008 Key_Code  output  4  code r*4+c of the most recently accepted single key press.
REQ-009 Key_Valid  output  1  one-cycle pulse on acceptance of a single-key press.
REQ-010 Key_Release  output  1  one-cycle pulse when debounced state returns to all-released.

Function
REQ-011 Col_Sig SHALL pass through a 2-flop synchronizer before any use.
REQ-012 A 16-bit tick counter SHALL count 0..T1MS and wrap to 0; the cycle with count == T1MS is the "tick".
REQ-013 A row index i (0..3) SHALL drive Row_Sig: i=0 -> 4'b1110, 1 -> 4'b1101, 2 -> 4'b1011, 3 -> 4'b0111; exactly one row low at all times.
REQ-014 On each tick, the synchronized columns SHALL be inverted and stored into snapshot bits i*4+3..i*4, then i SHALL advance (3 wraps to 0) on the same edge.
REQ-015 On the tick with i == 3 (scan complete), the completed 16-bit snapshot SHALL be compared with the previous complete snapshot, which is then replaced.
REQ-016 Stability counter: cleared to 0 if snapshot differs from previous, else incremented, saturating at DEB_SCANS.
REQ-017 When the new stability count equals DEB_SCANS and snapshot differs from Key_State, Key_State SHALL load the snapshot on that edge.
REQ-018 On such an update, if old Key_State == 0 and snapshot has exactly one bit set, Key_Valid SHALL be 1 for exactly the cycle following the edge, and Key_Code SHALL load that bit index on the same edge.
REQ-019 On such an update, if old Key_State != 0 and snapshot == 0, Key_Release SHALL be 1 for exactly the following cycle.
REQ-020 Multi-key snapshots and one-key-to-other-key transitions SHALL update Key_State only; no Key_Valid, Key_Code unchanged.
REQ-021 Key_Valid and Key_Release SHALL never assert simultaneously and SHALL be 0 on all other cycles.
REQ-022 Latency: a press stable from scan N (first scan capturing it) SHALL appear on Key_State at the end of scan N+DEB_SCANS.
REQ-023 Bounces changing the snapshot at any scan SHALL restart the stability count; no partial update of Key_State.

Reset
REQ-024 While RST=1 on a clock edge: tick counter 0, i 0, Row_Sig 4'b1110, snapshot and previous snapshot 0, stability counter 0, Key_State 16'h0000, Key_Code 4'h0, Key_Valid 0, Key_Release 0, synchronizer flops 4'b1111.
REQ-025 RST asserted mid-scan or mid-debounce SHALL discard all partial state; scanning restarts at row 0 on the first cycle after RST deasserts.
REQ-026 No output SHALL change except via a rising CLK edge (no asynchronous reset path).

Verification (T1MS=3, DEB_SCANS=2 unless stated)
REQ-027 Reset then idle (Col_Sig=4'hF) -> Row_Sig cycles 1110,1101,1011,0111 with 4 clocks per row; Key_State stays 0, no pulses.
REQ-028 Key row 2 col 1 held (Col_Sig[1] low while Row_Sig=1011) -> after 3 full scans Key_State=16'h0200, Key_Code=4'h9, Key_Valid one cycle; release -> 3 scans later Key_State=0, Key_Release one cycle.
REQ-029 Same key toggled every alternate scan for 10 scans -> Key_State stays 0, no Key_Valid.
REQ-030 Keys 0 and 15 pressed together -> Key_State=16'h8001, Key_Valid never asserts, Key_Code stays 0.
REQ-031 RST pulsed for one cycle during debounce of key 5 (stability count 1) -> all outputs at reset values; key still held yields Key_Valid only after a full fresh debounce from row 0.
REQ-032 DEB_SCANS=1, key 0 pressed -> Key_State=16'h0001 at end of the second scan capturing it, Key_Code=0, Key_Valid one cycle.
